// File: rtl/key_event_pkg.sv
// key_event_pkg: shared state encoding, counter width and 27 MHz timing defaults for key_event
package key_event_pkg;
  localparam int CNT_W = 25;
  typedef enum logic [2:0] {IDLE, PRESS1, WAIT2, PRESS2, LONG} state_t;
  localparam logic [CNT_W-1:0] LONG_CNT_27M   = 25'd27_000_000;
  localparam logic [CNT_W-1:0] DOUBLE_GAP_27M = 25'd8_100_000;
  localparam logic [CNT_W-1:0] REPEAT_CNT_27M = 25'd5_400_000;
endpackage

// File: rtl/key_event.sv
// key_event: classifies debounced presses into short/double/long/repeat one-cycle pulses.
// Ports: sys_clk, rst_in (async, active-low), key_press (onset pulse), key_state (held level),
//        short_press, double_press, long_press, repeat_press (registered pulses), busy (state != IDLE).
module key_event
  import key_event_pkg::*;
#(
  parameter logic [CNT_W-1:0] LONG_CNT   = LONG_CNT_27M,
  parameter logic [CNT_W-1:0] DOUBLE_GAP = DOUBLE_GAP_27M,
  parameter logic [CNT_W-1:0] REPEAT_CNT = REPEAT_CNT_27M
) (
  input  logic sys_clk,
  input  logic rst_in,
  input  logic key_press,
  input  logic key_state,
  output logic short_press,
  output logic double_press,
  output logic long_press,
  output logic repeat_press,
  output logic busy
);
  localparam logic [CNT_W-1:0] LONG_LAST   = LONG_CNT - 1'b1;
  localparam logic [CNT_W-1:0] GAP_LAST    = DOUBLE_GAP - 1'b1;
  localparam logic [CNT_W-1:0] REPEAT_LAST = REPEAT_CNT - 1'b1;
  state_t r_state, w_next;
  logic [CNT_W-1:0] r_cnt, w_cnt;
  logic r_short, r_double, r_long, r_repeat, r_busy;
  logic w_short, w_double, w_long, w_repeat;
  always_ff @(posedge sys_clk or negedge rst_in) begin
    if (!rst_in) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_short  <= 1'b0;
      r_double <= 1'b0;
      r_long   <= 1'b0;
      r_repeat <= 1'b0;
      r_busy   <= 1'b0;
    end else begin
      r_state  <= w_next;
      r_cnt    <= w_cnt;
      r_short  <= w_short;
      r_double <= w_double;
      r_long   <= w_long;
      r_repeat <= w_repeat;
      r_busy   <= w_next != IDLE;
    end
  end
  // release beats the long threshold, and a press beats the gap timeout
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = key_press ? PRESS1 : IDLE;
      PRESS1:  w_next = !key_state ? WAIT2 : (r_cnt == LONG_LAST ? LONG : PRESS1);
      WAIT2:   w_next = key_press ? PRESS2 : (r_cnt == GAP_LAST ? IDLE : WAIT2);
      PRESS2:  w_next = key_state ? PRESS2 : IDLE;
      LONG:    w_next = key_state ? LONG : IDLE;
      default: w_next = IDLE;
    endcase
  end
  // counter only runs in the timed states and restarts on any state change or repeat
  always_comb begin
    w_long   = r_state == PRESS1 && key_state && r_cnt == LONG_LAST;
    w_double = r_state == WAIT2 && key_press;
    w_short  = r_state == WAIT2 && !key_press && r_cnt == GAP_LAST;
    w_repeat = r_state == LONG && key_state && r_cnt == REPEAT_LAST;
    w_cnt    = (w_next != r_state || w_repeat || r_state inside {IDLE, PRESS2}) ? '0 : r_cnt + 1'b1;
  end
  assign short_press  = r_short;
  assign double_press = r_double;
  assign long_press   = r_long;
  assign repeat_press = r_repeat;
  assign busy         = r_busy;
endmodule

// File: tb/tb_key_event.sv
// tb_key_event: randomized and directed check of key_event against a timestamp-based gesture model
module tb_key_event;
  localparam int LONG = 20, GAP = 8, REP = 5;
  logic sys_clk = 0, rst_in = 0, key_press = 0, key_state = 0;
  logic short_press, double_press, long_press, repeat_press, busy;
  int errors = 0, checks = 0, cyc = 0, base = 0;
  int m_t = 0, t0 = 0, ph = 0;
  logic e_s = 0, e_d = 0, e_l = 0, e_r = 0;
  logic prev_ks = 0, rnd = 0, prev_busy = 0;
  int q_s[$], q_d[$], q_l[$], q_r[$], q_bf[$];
  int s0, d0, l0, r0, b0, tot0;
  key_event #(.LONG_CNT(25'd20), .DOUBLE_GAP(25'd8), .REPEAT_CNT(25'd5)) dut (
    .sys_clk(sys_clk), .rst_in(rst_in), .key_press(key_press), .key_state(key_state),
    .short_press(short_press), .double_press(double_press), .long_press(long_press),
    .repeat_press(repeat_press), .busy(busy)
  );
  always #5 sys_clk = ~sys_clk;
  always @(posedge sys_clk) cyc <= cyc + 1;
  // gesture model: phase 0 idle, 1 first hold, 2 release gap, 3 second hold, 4 long hold; ages from entry edge
  always @(posedge sys_clk or negedge rst_in) begin
    if (!rst_in) begin
      ph <= 0; e_s <= 0; e_d <= 0; e_l <= 0; e_r <= 0;
    end else begin
      m_t <= m_t + 1;
      e_s <= 0; e_d <= 0; e_l <= 0; e_r <= 0;
      case (ph)
        0: if (key_press) begin ph <= 1; t0 <= m_t; end
        1: if (!key_state) begin ph <= 2; t0 <= m_t; end
           else if (m_t - t0 == LONG) begin e_l <= 1; ph <= 4; t0 <= m_t; end
        2: if (key_press) begin e_d <= 1; ph <= 3; end
           else if (m_t - t0 == GAP) begin e_s <= 1; ph <= 0; end
        3: if (!key_state) ph <= 0;
        4: if (!key_state) ph <= 0;
           else if ((m_t - t0) % REP == 0) e_r <= 1;
        default: ph <= 0;
      endcase
    end
  end
  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask
  task automatic seg(input int upto, input logic ks);
    while (cyc + 1 <= base + upto) begin
      key_press = (ks && !prev_ks) || (rnd && $urandom_range(0, 15) == 0);
      key_state = ks;
      prev_ks = ks;
      @(negedge sys_clk);
    end
  endtask
  task automatic start();
    base = cyc;
    s0 = q_s.size(); d0 = q_d.size(); l0 = q_l.size(); r0 = q_r.size(); b0 = q_bf.size();
  endtask
  function automatic int total();
    return q_s.size() + q_d.size() + q_l.size() + q_r.size();
  endfunction
  initial begin
    fork
      forever begin
        @(negedge sys_clk);
        chk("outputs", {27'd0, short_press, double_press, long_press, repeat_press, busy},
            {27'd0, e_s, e_d, e_l, e_r, ph != 0});
        if (short_press) q_s.push_back(cyc + 1);
        if (double_press) q_d.push_back(cyc + 1);
        if (long_press) q_l.push_back(cyc + 1);
        if (repeat_press) q_r.push_back(cyc + 1);
        if (prev_busy && !busy) q_bf.push_back(cyc + 1);
        prev_busy = busy;
      end
    join_none
    repeat (3) @(negedge sys_clk);
    chk("reset_outs", {27'd0, short_press, double_press, long_press, repeat_press, busy}, 0);
    rst_in = 1;
    start(); seg(9, 0); seg(15, 1); seg(40, 0);
    chk("single_count", q_s.size() - s0, 1);
    chk("single_time", q_s[s0] - base, 25);
    chk("single_other", (q_d.size() - d0) + (q_l.size() - l0) + (q_r.size() - r0), 0);
    start(); seg(9, 0); seg(13, 1); seg(17, 0); seg(21, 1); seg(40, 0);
    chk("double_time", q_d[d0] - base, 19);
    chk("double_no_short", q_s.size() - s0, 0);
    chk("double_busy_fall", q_bf[b0] - base, 23);
    start(); seg(9, 0); seg(49, 1); seg(70, 0);
    chk("long_time", q_l[l0] - base, 31);
    chk("repeat_count", q_r.size() - r0, 3);
    chk("repeat_first", q_r[r0] - base, 36);
    chk("repeat_last", q_r[r0 + 2] - base, 46);
    start(); seg(9, 0); seg(13, 1); seg(21, 0); seg(26, 1); seg(45, 0);
    chk("gap_edge_double", q_d[d0] - base, 23);
    chk("gap_edge_no_short", q_s.size() - s0, 0);
    start(); seg(9, 0); seg(13, 1); seg(22, 0); seg(24, 1); seg(45, 0);
    chk("gap_late_short1", q_s[s0] - base, 23);
    chk("gap_late_short2", q_s[s0 + 1] - base, 34);
    chk("gap_late_no_double", q_d.size() - d0, 0);
    start(); seg(9, 0); seg(29, 1); seg(50, 0);
    chk("release_at_long_no_long", q_l.size() - l0, 0);
    chk("release_at_long_short", q_s[s0] - base, 39);
    start(); seg(9, 0); seg(38, 1);
    chk("rst_pre_busy", busy, 1);
    #2 rst_in = 0;
    #1 chk("rst_async_outs", {27'd0, short_press, double_press, long_press, repeat_press, busy}, 0);
    repeat (3) @(negedge sys_clk);
    rst_in = 1;
    tot0 = total();
    seg(60, 1);
    chk("rst_held_no_event", total() - tot0, 0);
    chk("rst_held_busy", busy, 0);
    seg(70, 0);
    rnd = 1;
    start();
    for (int i = 0; i < 200; i++) seg(cyc - base + $urandom_range(1, 30), i % 2 == 0);
    rnd = 0;
    seg(cyc - base + 40, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
